// File: rtl/cmos_capture.sv
// cmos_capture: CMOS sensor front end. Drops the first SKIP_FRAMES frames
// after reset, packs byte pairs into RGB565 pixels, clips each frame to
// H_ACTIVE x V_ACTIVE and presents the pixels on a one-entry valid/ready register.
// Latency: the second byte of a pair, sampled at edge N, shows as pix_valid after edge N+2.
// Backpressure: a new pixel that meets a held, unaccepted pixel is dropped and sets sticky ovf.
// Ports:
//   CLK, RST                     pixel clock, synchronous active-high reset
//   cmos_vsyn/href/data          raw sensor pins (vsyn high = vertical blank)
//   pix_data/valid/ready         RGB565 pixel stream, first byte of a pair = [15:8]
//   pix_sof / pix_eol            pixel markers for x=0,y=0 and x=H_ACTIVE-1
//   frame_done, frame_cnt        end-of-captured-frame pulse and 8-bit wrapping counter
//   ovf, line_err                sticky: pixel lost to backpressure / odd byte count on a line
module cmos_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmos_vsyn,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        ovf,
  output logic        line_err
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int SW = $clog2(SKIP_FRAMES + 2);

  localparam logic [XW-1:0] X_MAX  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(V_ACTIVE);
  localparam logic [SW-1:0] SKIP_N = SW'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_WAIT,
    ST_ACTIVE
  } state_t;

  // Input registers (d1) and the edge-detect history (d2).
  logic       vsyn_d1_q, vsyn_d2_q, href_d1_q, href_d2_q;
  logic [7:0] data_d1_q;

  state_t          state_q, state_d;
  logic [SW-1:0]   skip_q, skip_d;
  logic            phase_q, phase_d;
  logic [7:0]      hi_q, hi_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;

  // Formed-pixel stage between packing and the output register.
  logic            frm_vld_q, frm_vld_d;
  logic [15:0]     frm_dat_q, frm_dat_d;
  logic            frm_sof_q, frm_sof_d;
  logic            frm_eol_q, frm_eol_d;

  // Output register and status.
  logic            out_vld_q, out_vld_d;
  logic [15:0]     out_dat_q, out_dat_d;
  logic            out_sof_q, out_sof_d;
  logic            out_eol_q, out_eol_d;
  logic            done_q, done_d;
  logic [7:0]      fcnt_q, fcnt_d;
  logic            ovf_q, ovf_d;
  logic            lerr_q, lerr_d;

  logic vs_rise, vs_fall, hr_fall;

  assign vs_rise = vsyn_d1_q & ~vsyn_d2_q;
  assign vs_fall = ~vsyn_d1_q & vsyn_d2_q;
  assign hr_fall = ~href_d1_q & href_d2_q;

  // Frame FSM, byte packing and window bookkeeping.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    phase_d   = phase_q;
    hi_d      = hi_q;
    x_d       = x_q;
    y_d       = y_q;
    frm_vld_d = 1'b0;
    frm_dat_d = frm_dat_q;
    frm_sof_d = frm_sof_q;
    frm_eol_d = frm_eol_q;
    done_d    = 1'b0;
    fcnt_d    = fcnt_q;
    lerr_d    = lerr_q;

    case (state_q)
      ST_IDLE: begin
        // The first vsync edge only aligns us to a frame boundary; it is not counted.
        if (vs_rise) begin
          skip_d  = '0;
          state_d = (SKIP_FRAMES == 0) ? ST_WAIT : ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (vs_rise) begin
          skip_d = skip_q + SW'(1);
          if (skip_q + SW'(1) == SKIP_N) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (vs_fall) begin
          state_d = ST_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (vs_rise) begin
          // Any partial line is abandoned at the frame boundary.
          state_d = ST_WAIT;
          done_d  = 1'b1;
          fcnt_d  = fcnt_q + 8'd1;
          phase_d = 1'b0;
        end else if (hr_fall) begin
          phase_d = 1'b0;
          if (phase_q) lerr_d = 1'b1;
          // A line that formed no pixel does not advance y.
          if (x_q != '0) begin
            x_d = '0;
            if (y_q < Y_MAX) y_d = y_q + YW'(1);
          end
        end else if (href_d1_q) begin
          if (!phase_q) begin
            hi_d    = data_d1_q;
            phase_d = 1'b1;
          end else begin
            phase_d   = 1'b0;
            frm_vld_d = (x_q < X_MAX) && (y_q < Y_MAX);
            frm_dat_d = {hi_q, data_d1_q};
            frm_sof_d = (x_q == '0) && (y_q == '0);
            frm_eol_d = (x_q == X_LAST);
            if (x_q < X_MAX) x_d = x_q + XW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One-entry output register; it drains in any FSM state.
  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_sof_d = out_sof_q;
    out_eol_d = out_eol_q;
    ovf_d     = ovf_q;

    if (out_vld_q && pix_ready) out_vld_d = 1'b0;

    if (frm_vld_q) begin
      if (!out_vld_q || pix_ready) begin
        out_vld_d = 1'b1;
        out_dat_d = frm_dat_q;
        out_sof_d = frm_sof_q;
        out_eol_d = frm_eol_q;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vsyn_d1_q <= 1'b0;
      vsyn_d2_q <= 1'b0;
      href_d1_q <= 1'b0;
      href_d2_q <= 1'b0;
      data_d1_q <= '0;
      state_q   <= ST_IDLE;
      skip_q    <= '0;
      phase_q   <= 1'b0;
      hi_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      frm_vld_q <= 1'b0;
      frm_dat_q <= '0;
      frm_sof_q <= 1'b0;
      frm_eol_q <= 1'b0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_sof_q <= 1'b0;
      out_eol_q <= 1'b0;
      done_q    <= 1'b0;
      fcnt_q    <= '0;
      ovf_q     <= 1'b0;
      lerr_q    <= 1'b0;
    end else begin
      vsyn_d1_q <= cmos_vsyn;
      vsyn_d2_q <= vsyn_d1_q;
      href_d1_q <= cmos_href;
      href_d2_q <= href_d1_q;
      data_d1_q <= cmos_data;
      state_q   <= state_d;
      skip_q    <= skip_d;
      phase_q   <= phase_d;
      hi_q      <= hi_d;
      x_q       <= x_d;
      y_q       <= y_d;
      frm_vld_q <= frm_vld_d;
      frm_dat_q <= frm_dat_d;
      frm_sof_q <= frm_sof_d;
      frm_eol_q <= frm_eol_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_sof_q <= out_sof_d;
      out_eol_q <= out_eol_d;
      done_q    <= done_d;
      fcnt_q    <= fcnt_d;
      ovf_q     <= ovf_d;
      lerr_q    <= lerr_d;
    end
  end

  assign pix_data   = out_dat_q;
  assign pix_valid  = out_vld_q;
  assign pix_sof    = out_vld_q & out_sof_q;
  assign pix_eol    = out_vld_q & out_eol_q;
  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;
  assign ovf        = ovf_q;
  assign line_err   = lerr_q;

endmodule

// File: tb/tb_cmos_capture.sv
// Bench for cmos_capture: small-window instance (SKIP_FRAMES=2, 4x2) plus a
// SKIP_FRAMES=0 instance for the frame counter wrap. Accepted pixels are
// compared against a line/pixel arithmetic model of the expected stream.
module tb_cmos_capture;
  localparam int H = 4;
  localparam int V = 2;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, cmos_vsyn, cmos_href, pix_ready, pix_ready0;
  logic [7:0]  cmos_data;
  logic [15:0] pix_data, pix_data0;
  logic        pix_valid, pix_sof, pix_eol, frame_done, ovf, line_err;
  logic        pix_valid0, pix_sof0, pix_eol0, frame_done0, ovf0, line_err0;
  logic [7:0]  frame_cnt, frame_cnt0;

  cmos_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(2)) dut (
    .CLK(CLK), .RST(RST), .cmos_vsyn(cmos_vsyn), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .ovf(ovf), .line_err(line_err));

  cmos_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(0)) dut0 (
    .CLK(CLK), .RST(RST), .cmos_vsyn(cmos_vsyn), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .pix_data(pix_data0), .pix_valid(pix_valid0),
    .pix_ready(pix_ready0), .pix_sof(pix_sof0), .pix_eol(pix_eol0),
    .frame_done(frame_done0), .frame_cnt(frame_cnt0), .ovf(ovf0), .line_err(line_err0));

  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] exp_q[$];   // {sof, eol, pixel}
  logic [17:0] got_q[$];
  int valid_cnt, done_cnt, done0_cnt;
  int m_y;
  bit m_cap;

  // Monitor away from the active edge: a handshake seen here completes at the next posedge.
  always @(negedge CLK) begin
    if (pix_valid && pix_ready) got_q.push_back({pix_sof, pix_eol, pix_data});
    if (pix_valid) valid_cnt++;
    if (frame_done) done_cnt++;
    if (frame_done0) done0_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Vertical blank pulse: ends the previous frame and opens the next one.
  task automatic vs_pulse(input bit cap_next);
    cmos_vsyn = 1'b1;
    tick(4);
    cmos_vsyn = 1'b0;
    tick(3);
    m_y   = 0;
    m_cap = cap_next;
  endtask

  // Drives one line and, for a captured frame, appends the pixels it should forward.
  task automatic drive_line(input int n, input bit rnd);
    logic [7:0] b[$];
    for (int i = 0; i < n; i++) b.push_back(rnd ? 8'($urandom) : 8'(i));
    if (n > 0) begin
      cmos_href = 1'b1;
      for (int i = 0; i < n; i++) begin
        cmos_data = b[i];
        tick(1);
      end
      cmos_href = 1'b0;
      cmos_data = 8'h00;
    end
    tick(3);
    if (m_cap) begin
      for (int p = 0; p < n / 2; p++)
        if (p < H && m_y < V)
          exp_q.push_back({(p == 0 && m_y == 0), (p == H - 1), b[2*p], b[2*p+1]});
      if (n / 2 > 0) m_y++;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    tick(2);
    n_cmp++;
    if ({pix_data, pix_valid, pix_sof, pix_eol, frame_done, frame_cnt, ovf, line_err} !== 31'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got data=%h vld=%b cnt=%h ovf=%b lerr=%b required all 0",
               pix_data, pix_valid, frame_cnt, ovf, line_err);
    end
    n_cmp++;
    if ({pix_data0, pix_valid0, frame_done0, frame_cnt0, ovf0, line_err0} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_outputs0: got data=%h vld=%b cnt=%h required all 0", pix_data0, pix_valid0, frame_cnt0);
    end
    RST = 1'b0;
    tick(2);
  endtask

  task automatic test_settling;
    exp_q.delete(); got_q.delete();
    valid_cnt = 0; done_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      vs_pulse(1'b0);
      drive_line(8, 1'b0);
      drive_line(8, 1'b0);
    end
    n_cmp++;
    if (valid_cnt !== 0) begin
      n_bad++;
      $display("FAIL settle_skip_valid: got %0d valid cycles required 0", valid_cnt);
    end
    vs_pulse(1'b1);
    drive_line(8, 1'b0);
    drive_line(8, 1'b0);
    vs_pulse(1'b1);
    tick(4);
    n_cmp++;
    if (got_q.size() !== 8) begin
      n_bad++;
      $display("FAIL settle_count: got %0d pixels required 8", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL settle_pix[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (got_q.size() > 0 && got_q[0] !== {2'b10, 16'h0001}) begin
      n_bad++;
      $display("FAIL settle_first: got %h required %h", got_q[0], {2'b10, 16'h0001});
    end
    n_cmp++;
    if (done_cnt !== 1 || frame_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL settle_done: got done=%0d cnt=%0d required done=1 cnt=1", done_cnt, frame_cnt);
    end
    n_cmp++;
    if (ovf !== 1'b0 || line_err !== 1'b0) begin
      n_bad++;
      $display("FAIL settle_flags: got ovf=%b lerr=%b required 0 0", ovf, line_err);
    end
  endtask

  task automatic test_latency;
    cmos_href = 1'b1;
    cmos_data = 8'hAB;
    tick(1);
    cmos_data = 8'hCD;
    @(posedge CLK);   // edge N samples 0xCD
    #1;
    cmos_href = 1'b0;
    cmos_data = 8'h00;
    n_cmp++;
    if (pix_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL lat_n0: got valid=%b required 0", pix_valid);
    end
    tick(1);
    n_cmp++;
    if (pix_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL lat_n1: got valid=%b required 0", pix_valid);
    end
    tick(1);
    n_cmp++;
    if (pix_valid !== 1'b1 || pix_data !== 16'hABCD) begin
      n_bad++;
      $display("FAIL lat_n2: got valid=%b data=%h required 1 abcd", pix_valid, pix_data);
    end
    tick(4);
  endtask

  task automatic test_backpressure;
    vs_pulse(1'b0);
    pix_ready = 1'b0;
    drive_line(6, 1'b0);
    n_cmp++;
    if (pix_valid !== 1'b1 || pix_data !== 16'h0001 || ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_hold: got valid=%b data=%h ovf=%b required 1 0001 1", pix_valid, pix_data, ovf);
    end
    got_q.delete();
    pix_ready = 1'b1;
    tick(4);
    n_cmp++;
    if (got_q.size() !== 1) begin
      n_bad++;
      $display("FAIL bp_handshakes: got %0d required 1", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0][15:0] !== 16'h0001) begin
        n_bad++;
        $display("FAIL bp_data: got %h required 0001", got_q[0][15:0]);
      end
    end
  endtask

  task automatic test_window;
    exp_q.delete(); got_q.delete();
    vs_pulse(1'b1);
    for (int l = 0; l < 3; l++) drive_line(12, 1'b1);
    tick(4);
    n_cmp++;
    if (got_q.size() !== 8 || exp_q.size() !== 8) begin
      n_bad++;
      $display("FAIL win_count: got %0d model %0d required 8", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL win_pix[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_odd_line;
    exp_q.delete(); got_q.delete();
    vs_pulse(1'b1);
    n_cmp++;
    if (line_err !== 1'b0) begin
      n_bad++;
      $display("FAIL odd_pre: got line_err=%b required 0", line_err);
    end
    drive_line(7, 1'b1);
    drive_line(8, 1'b1);
    tick(4);
    n_cmp++;
    if (line_err !== 1'b1) begin
      n_bad++;
      $display("FAIL odd_lerr: got line_err=%b required 1", line_err);
    end
    n_cmp++;
    if (got_q.size() !== 7) begin
      n_bad++;
      $display("FAIL odd_count: got %0d required 7", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL odd_pix[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random;
    exp_q.delete(); got_q.delete();
    for (int f = 0; f < 4; f++) begin
      int nl;
      vs_pulse(1'b1);
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++) drive_line($urandom_range(0, 12), 1'b1);
    end
    tick(4);
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL rnd_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL rnd_pix[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midline;
    vs_pulse(1'b0);
    cmos_href = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmos_data = 8'(8'h40 + i);
      tick(1);
    end
    RST = 1'b1;
    tick(1);
    cmos_href = 1'b0;
    cmos_data = 8'h00;
    tick(1);
    n_cmp++;
    if ({pix_data, pix_valid, pix_sof, pix_eol, frame_done, frame_cnt, ovf, line_err} !== 31'd0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got data=%h vld=%b cnt=%h ovf=%b lerr=%b required all 0",
               pix_data, pix_valid, frame_cnt, ovf, line_err);
    end
    RST = 1'b0;
    tick(2);
    exp_q.delete(); got_q.delete();
    valid_cnt = 0; done_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      vs_pulse(1'b0);
      drive_line(8, 1'b1);
      drive_line(8, 1'b1);
    end
    n_cmp++;
    if (valid_cnt !== 0 || done_cnt !== 0) begin
      n_bad++;
      $display("FAIL rst_mid_skip: got valid=%0d done=%0d required 0 0", valid_cnt, done_cnt);
    end
    vs_pulse(1'b1);
    drive_line(8, 1'b1);
    drive_line(8, 1'b1);
    vs_pulse(1'b0);
    tick(4);
    n_cmp++;
    if (got_q.size() !== 8 || frame_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL rst_mid_capture: got %0d pixels cnt=%0d required 8 1", got_q.size(), frame_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL rst_mid_pix[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap;
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(2);
    done0_cnt = 0;
    for (int f = 0; f < 255; f++) begin
      vs_pulse(1'b0);
      drive_line(2, 1'b1);
    end
    vs_pulse(1'b0);
    n_cmp++;
    if (done0_cnt !== 255 || frame_cnt0 !== 8'd255) begin
      n_bad++;
      $display("FAIL wrap_255: got done=%0d cnt=%0d required 255 255", done0_cnt, frame_cnt0);
    end
    drive_line(2, 1'b1);
    vs_pulse(1'b0);
    n_cmp++;
    if (done0_cnt !== 256 || frame_cnt0 !== 8'd0) begin
      n_bad++;
      $display("FAIL wrap_256: got done=%0d cnt=%0d required 256 0", done0_cnt, frame_cnt0);
    end
  endtask

  initial begin
    RST = 1'b1;
    cmos_vsyn = 1'b0;
    cmos_href = 1'b0;
    cmos_data = 8'h00;
    pix_ready = 1'b1;
    pix_ready0 = 1'b1;
    m_cap = 1'b0;
    m_y = 0;
    tick(3);
    test_reset;
    test_settling;
    test_latency;
    test_backpressure;
    test_window;
    test_odd_line;
    test_random;
    test_reset_midline;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
